// File: rtl/seq_div_signed_8_bit_pkg.sv
// Shared definitions for the sequential signed divider.
// State encoding and a magnitude helper shared with the multipliers.
package seq_div_signed_8_bit_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  localparam int ABS_W = 32;

  // Input is sign-extended to ABS_W bits; one extra bit holds |MIN|.
  function automatic logic [ABS_W:0] abs_ext(
    input logic [ABS_W-1:0] x
  );
    logic [ABS_W:0] v;
    v = {x[ABS_W-1], x};
    return x[ABS_W-1] ? -v : v;
  endfunction

endpackage

// File: rtl/seq_div_signed_8_bit_div_step_restoring.sv
// One restoring-division iteration:
// shift in the next dividend bit, trial-subtract the divisor.
module seq_div_signed_8_bit_div_step_restoring #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0] i_rem_in,
  input  logic           i_dvd_msb,
  input  logic [WIDTH:0] i_divisor,
  output logic [WIDTH:0] o_rem_out,
  output logic           o_q_bit
);

  logic [WIDTH+1:0] w_shift;
  logic [WIDTH+1:0] w_trial;

  assign w_shift   = {i_rem_in, i_dvd_msb};
  assign w_trial   = w_shift - {1'b0, i_divisor};
  assign o_q_bit   = ~w_trial[WIDTH+1];
  assign o_rem_out = o_q_bit ? w_trial[WIDTH:0]
                             : w_shift[WIDTH:0];

endmodule

// File: rtl/seq_div_signed_8_bit.sv
// Iterative signed divider: restoring division on magnitudes,
// one quotient bit per clock, then a sign-correction cycle.
module seq_div_signed_8_bit
  import seq_div_signed_8_bit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  input  logic             action,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done,
  output logic             busy,
  output logic             div_zero,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nx;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH:0]   r_dvs;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dz_sel;
  logic             r_ov_sel;

  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_remo;
  logic             r_done;
  logic             r_dz;
  logic             r_ov;

  logic [ABS_W:0]   w_abs1;
  logic [ABS_W:0]   w_abs2;
  logic [WIDTH:0]   w_rem_nx;
  logic             w_qbit;
  logic             w_start;
  logic             w_calc;
  logic             w_num2_zero;
  logic             w_min_m1;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_mag;
  logic [WIDTH-1:0] w_r_fix;
  logic             w_unused_hi;

  assign w_abs1 = abs_ext(ABS_W'($signed(num1)));
  assign w_abs2 = abs_ext(ABS_W'($signed(num2)));

  assign w_num2_zero = (num2 == '0);
  assign w_min_m1    = (num1 == {1'b1, {(WIDTH-1){1'b0}}})
                    && (num2 == '1);

  assign w_start = (r_state == IDLE) && action;
  assign w_calc  = (r_state == CALC);

  // Remainder MSB stays zero since rem < divisor <= 2^(WIDTH-1).
  assign w_unused_hi = ^{w_abs1[ABS_W:WIDTH],
                         w_abs2[ABS_W:WIDTH+1],
                         r_rem[WIDTH]};

  seq_div_signed_8_bit_div_step_restoring #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_rem_in  (r_rem),
    .i_dvd_msb (r_dvd[WIDTH-1]),
    .i_divisor (r_dvs),
    .o_rem_out (w_rem_nx),
    .o_q_bit   (w_qbit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      IDLE: if (action)
              w_state_nx = w_num2_zero ? FIX : CALC;
      CALC: if (r_cnt == CW'(1))
              w_state_nx = FIX;
      FIX:  w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_rem    <= '0;
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz_sel <= 1'b0;
      r_ov_sel <= 1'b0;
    end else begin
      unique case (1'b1)
        w_start: begin
          r_dvd    <= w_abs1[WIDTH-1:0];
          r_dvs    <= w_abs2[WIDTH:0];
          r_rem    <= '0;
          r_cnt    <= CW'(WIDTH);
          r_neg_q  <= num1[WIDTH-1] ^ num2[WIDTH-1];
          r_neg_r  <= num1[WIDTH-1];
          r_dz_sel <= w_num2_zero;
          r_ov_sel <= w_min_m1;
        end
        w_calc: begin
          r_rem <= w_rem_nx;
          r_dvd <= {r_dvd[WIDTH-2:0], w_qbit};
          r_cnt <= r_cnt - CW'(1);
        end
        default: ;
      endcase
    end
  end

  // On divide-by-zero r_dvd still holds |num1|, so the sign fix restores num1.
  always_comb begin
    w_q_fix = r_neg_q ? -r_dvd : r_dvd;
    w_r_mag = r_rem[WIDTH-1:0];
    if (r_dz_sel) begin
      w_q_fix = '1;
      w_r_mag = r_dvd;
    end
    w_r_fix = r_neg_r ? -w_r_mag : w_r_mag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_quot <= '0;
      r_remo <= '0;
      r_done <= 1'b0;
      r_dz   <= 1'b0;
      r_ov   <= 1'b0;
    end else begin
      r_done <= (r_state == FIX);
      if (r_state == FIX) begin
        r_quot <= w_q_fix;
        r_remo <= w_r_fix;
        r_dz   <= r_dz_sel;
        r_ov   <= r_ov_sel;
      end
    end
  end

  assign quotient  = r_quot;
  assign remainder = r_remo;
  assign done      = r_done;
  assign div_zero  = r_dz;
  assign overflow  = r_ov;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_seq_div_signed_8_bit.sv
// Directed, table-driven bench for the sequential signed divider.
module tb_seq_div_signed_8_bit;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         action = 1'b0;
  logic [W-1:0] num1 = '0;
  logic [W-1:0] num2 = '0;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         done;
  logic         busy;
  logic         div_zero;
  logic         overflow;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int a;
    int b;
    int q;
    int r;
    int dz;
    int ov;
    int lat;
  } vec_t;

  vec_t tv[15];

  seq_div_signed_8_bit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .num1      (num1),
    .num2      (num2),
    .action    (action),
    .quotient  (quotient),
    .remainder (remainder),
    .done      (done),
    .busy      (busy),
    .div_zero  (div_zero),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // lat counts edges from the accept edge up to the one that raises done.
  task automatic run_op(input int a, input int b,
                        output int lat, output int busy_n);
    @(negedge clk);
    num1   = W'(a);
    num2   = W'(b);
    action = 1'b1;
    @(posedge clk);
    #1;
    action = 1'b0;
    lat    = 1;
    busy_n = 0;
    while (!done && lat < 40) begin
      busy_n += int'(busy);
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    int bn;
    int nd;

    tv[0]  = '{100,    7,   14,    2, 0, 0, 10};
    tv[1]  = '{10,    -9,   -1,    1, 0, 0, 10};
    tv[2]  = '{-3,    -7,    0,   -3, 0, 0, 10};
    tv[3]  = '{-100,   7,  -14,   -2, 0, 0, 10};
    tv[4]  = '{7,      0,   -1,    7, 1, 0,  2};
    tv[5]  = '{-128,  -1, -128,    0, 0, 1, 10};
    tv[6]  = '{127, -128,    0,  127, 0, 0, 10};
    tv[7]  = '{-128,   1, -128,    0, 0, 0, 10};
    tv[8]  = '{-128,   0,   -1, -128, 1, 0,  2};
    tv[9]  = '{0,      5,    0,    0, 0, 0, 10};
    tv[10] = '{-7,     2,   -3,   -1, 0, 0, 10};
    tv[11] = '{5,      5,    1,    0, 0, 0, 10};
    tv[12] = '{127,    1,  127,    0, 0, 0, 10};
    tv[13] = '{-1,  -128,    0,   -1, 0, 0, 10};
    tv[14] = '{-128, 127,   -1,   -1, 0, 0, 10};

    #12;
    chk("rst_quot", int'(quotient), 0);
    chk("rst_rem",  int'(remainder), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_dz",   int'(div_zero), 0);
    chk("rst_ov",   int'(overflow), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      run_op(tv[i].a, tv[i].b, lat, bn);
      chk($sformatf("v%0d_lat", i),  lat, tv[i].lat);
      chk($sformatf("v%0d_busy", i), bn, tv[i].lat - 1);
      chk($sformatf("v%0d_q", i),  int'($signed(quotient)), tv[i].q);
      chk($sformatf("v%0d_r", i),  int'($signed(remainder)), tv[i].r);
      chk($sformatf("v%0d_dz", i), int'(div_zero), tv[i].dz);
      chk($sformatf("v%0d_ov", i), int'(overflow), tv[i].ov);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_pulse", i), int'(done), 0);
      chk($sformatf("v%0d_hold", i),
          int'($signed(quotient)), tv[i].q);
    end

    // action held high: mid-operation strobes ignored, back-to-back accept
    @(negedge clk);
    num1   = W'(50);
    num2   = W'(5);
    action = 1'b1;
    @(posedge clk);
    #1;
    num1 = W'(9);
    num2 = W'(2);
    lat  = 1;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("b2b_lat1", lat, 10);
    chk("b2b_q1", int'($signed(quotient)), 10);
    chk("b2b_r1", int'($signed(remainder)), 0);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!done && lat < 40);
    action = 1'b0;
    chk("b2b_gap", lat, 10);
    chk("b2b_q2", int'($signed(quotient)), 4);
    chk("b2b_r2", int'($signed(remainder)), 1);

    // async reset in the middle of CALC
    @(negedge clk);
    num1   = W'(20);
    num2   = W'(3);
    action = 1'b1;
    @(posedge clk);
    #1;
    action = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_quot", int'(quotient), 0);
    chk("arst_rem",  int'(remainder), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      nd += int'(done);
    end
    chk("arst_nodone", nd, 0);
    chk("arst_idle", int'(busy), 0);
    run_op(20, 3, lat, bn);
    chk("post_lat", lat, 10);
    chk("post_q", int'($signed(quotient)), 6);
    chk("post_r", int'($signed(remainder)), 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
